// File: rtl/sdram_frame_writer_if.sv
// Pixel-stream input and dual write-FIFO output bundle for sdram_frame_writer.
// The master side is the frame writer; the slave side is the camera/FIFO environment.
interface sdram_frame_writer_if;
    logic        iFVAL;
    logic        iDVAL;
    logic [9:0]  iRED;
    logic [9:0]  iGREEN;
    logic [9:0]  iBLUE;
    logic        iWR1_FULL;
    logic        iWR2_FULL;
    logic [15:0] oWR1_DATA;
    logic        oWR1;
    logic [15:0] oWR2_DATA;
    logic        oWR2;
    logic        oWR_LOAD;

    modport master (
        input  iFVAL, iDVAL, iRED, iGREEN, iBLUE, iWR1_FULL, iWR2_FULL,
        output oWR1_DATA, oWR1, oWR2_DATA, oWR2, oWR_LOAD
    );

    modport slave (
        output iFVAL, iDVAL, iRED, iGREEN, iBLUE, iWR1_FULL, iWR2_FULL,
        input  oWR1_DATA, oWR1, oWR2_DATA, oWR2, oWR_LOAD
    );
endinterface

// File: rtl/sdram_frame_writer.sv
// Splits 30-bit RGB pixels across two 16-bit SDRAM write FIFOs, reloads the FIFOs
// in vertical blanking before each frame and reports per-frame capture status.
module sdram_frame_writer #(
    parameter int FRAME_PIXELS = 307200,
    parameter int LOAD_CYCLES  = 4,
    parameter int PCNT_W       = 19
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  iENABLE,
    sdram_frame_writer_if.master  pix,
    output logic                  oFRAME_DONE,
    output logic                  oFRAME_OK,
    output logic                  oOVERFLOW,
    output logic [15:0]           oFRAME_CNT,
    output logic [PCNT_W-1:0]     oPIX_CNT
);
    typedef enum logic [2:0] {IDLE, LOAD, ARMED, ACTIVE, DROP} state_t;

    localparam logic [PCNT_W-1:0] FRAME_LEN = PCNT_W'(FRAME_PIXELS);
    localparam logic [3:0]        LOAD_LAST = 4'(LOAD_CYCLES - 1);

    state_t              state_q, state_d;
    logic                fval_q, fval_d;
    logic [3:0]          load_cnt_q, load_cnt_d;
    logic                wr_load_q, wr_load_d;
    logic                wr_q, wr_d;
    logic [15:0]         wr1_data_q, wr1_data_d;
    logic [15:0]         wr2_data_q, wr2_data_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                overflow_q, overflow_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;

    logic                rise, fall, qual, full, start, finish, good;
    logic [PCNT_W-1:0]   cnt_base;

    always_comb begin
        rise        = pix.iFVAL & ~fval_q;
        fall        = ~pix.iFVAL & fval_q;
        qual        = pix.iFVAL & pix.iDVAL;
        full        = pix.iWR1_FULL | pix.iWR2_FULL;
        start       = 1'b0;
        finish      = 1'b0;
        good        = 1'b0;
        state_d     = state_q;
        fval_d      = pix.iFVAL;
        load_cnt_d  = load_cnt_q;
        wr_load_d   = 1'b0;
        wr_d        = 1'b0;
        wr1_data_d  = wr1_data_q;
        wr2_data_d  = wr2_data_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        pix_cnt_d   = pix_cnt_q;

        case (state_q)
            IDLE: begin
                // Only start the reload sequence in blanking so a frame is never joined mid-way.
                if (iENABLE && !pix.iFVAL) begin
                    state_d    = LOAD;
                    wr_load_d  = 1'b1;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                if (rise) begin
                    state_d = DROP;
                end else if (load_cnt_q == LOAD_LAST) begin
                    state_d = ARMED;
                end else begin
                    wr_load_d  = 1'b1;
                    load_cnt_d = load_cnt_q + 4'd1;
                end
            end
            ARMED: begin
                if (!iENABLE) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d     = ACTIVE;
                    start       = 1'b1;
                    frame_err_d = 1'b0;
                    pix_cnt_d   = '0;
                end
            end
            ACTIVE:  finish = fall;
            DROP:    finish = fall;
            default: state_d = IDLE;
        endcase

        // The rise cycle already counts as ACTIVE so its pixel is not lost.
        cnt_base = start ? '0 : pix_cnt_q;
        if ((state_q == ACTIVE || start) && qual) begin
            if (full) begin
                overflow_d  = 1'b1;
                frame_err_d = 1'b1;
                state_d     = DROP;
            end else if (cnt_base < FRAME_LEN) begin
                wr_d       = 1'b1;
                wr1_data_d = {1'b0, pix.iGREEN[9:5], pix.iBLUE};
                wr2_data_d = {1'b0, pix.iGREEN[4:0], pix.iRED};
                pix_cnt_d  = cnt_base + PCNT_W'(1);
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if (finish) begin
            good   = (state_q == ACTIVE) && !frame_err_q && (pix_cnt_q == FRAME_LEN);
            done_d = 1'b1;
            ok_d   = good;
            if (good) frame_cnt_d = frame_cnt_q + 16'd1;
            if (iENABLE) begin
                state_d    = LOAD;
                wr_load_d  = 1'b1;
                load_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            fval_q      <= 1'b0;
            load_cnt_q  <= '0;
            wr_load_q   <= 1'b0;
            wr_q        <= 1'b0;
            wr1_data_q  <= '0;
            wr2_data_q  <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            pix_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fval_q      <= fval_d;
            load_cnt_q  <= load_cnt_d;
            wr_load_q   <= wr_load_d;
            wr_q        <= wr_d;
            wr1_data_q  <= wr1_data_d;
            wr2_data_q  <= wr2_data_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign pix.oWR1      = wr_q;
    assign pix.oWR2      = wr_q;
    assign pix.oWR1_DATA = wr1_data_q;
    assign pix.oWR2_DATA = wr2_data_q;
    assign pix.oWR_LOAD  = wr_load_q;
    assign oFRAME_DONE   = done_q;
    assign oFRAME_OK     = ok_q;
    assign oOVERFLOW     = overflow_q;
    assign oFRAME_CNT    = frame_cnt_q;
    assign oPIX_CNT      = pix_cnt_q;
endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer with a 16-pixel frame and a 4-cycle reload pulse.
module tb_sdram_frame_writer;
    localparam int FP = 16;
    localparam int LC = 4;
    localparam int PW = 5;
    localparam int NONE = 1000;

    typedef struct {
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
        logic [15:0] d1;
        logic [15:0] d2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          done;
    logic          ok;
    logic          ovf;
    logic [15:0]   fcnt;
    logic [PW-1:0] pcnt;

    vec_t vecs [5];
    int   n_chk = 0;
    int   n_pass = 0;
    int   strobes_tot = 0;
    int   loads_tot = 0;
    int   dones_tot = 0;
    int   load_base;
    int   strobe_base;
    int   done_base;

    sdram_frame_writer_if bus();

    sdram_frame_writer #(.FRAME_PIXELS(FP), .LOAD_CYCLES(LC), .PCNT_W(PW)) dut (
        .CLK(clk), .RESET(rst), .iENABLE(en), .pix(bus.master),
        .oFRAME_DONE(done), .oFRAME_OK(ok), .oOVERFLOW(ovf),
        .oFRAME_CNT(fcnt), .oPIX_CNT(pcnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.oWR1)     strobes_tot <= strobes_tot + 1;
        if (bus.oWR_LOAD) loads_tot   <= loads_tot + 1;
        if (done)         dones_tot   <= dones_tot + 1;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_pix(input int k);
        bus.iFVAL = 1'b1;
        bus.iDVAL = 1'b1;
        bus.iRED   = vecs[k].r;
        bus.iGREEN = vecs[k].g;
        bus.iBLUE  = vecs[k].b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr1"},   32'(bus.oWR1), 0);
        chk({tag, "_wr2"},   32'(bus.oWR2), 0);
        chk({tag, "_data1"}, 32'(bus.oWR1_DATA), 0);
        chk({tag, "_data2"}, 32'(bus.oWR2_DATA), 0);
        chk({tag, "_load"},  32'(bus.oWR_LOAD), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_ok"},    32'(ok), 0);
        chk({tag, "_ovf"},   32'(ovf), 0);
        chk({tag, "_fcnt"},  32'(fcnt), 0);
        chk({tag, "_pcnt"},  32'(pcnt), 0);
    endtask

    task automatic blank(input int exp_loads);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        repeat (8) cyc();
        chk("load_cycles", loads_tot - load_base, exp_loads);
    endtask

    task automatic run_frame(input int n, input int full_idx, input bit rise_pix, input bit cyc_vecs,
                             input int en_on_at, input int en_off_at, input bit armed,
                             input bit exp_ok, input int exp_fcnt);
        int   acc;
        int   k;
        logic exp_w;
        acc = 0;
        load_base   = loads_tot;
        strobe_base = strobes_tot;
        done_base   = dones_tot;
        if (!rise_pix) begin
            bus.iFVAL = 1'b1;
            bus.iDVAL = 1'b0;
            cyc();
        end
        for (int i = 0; i < n; i++) begin
            k = cyc_vecs ? i % 5 : 0;
            drive_pix(k);
            bus.iWR2_FULL = (i == full_idx);
            if (i == en_on_at)  en = 1'b1;
            if (i == en_off_at) en = 1'b0;
            cyc();
            exp_w = armed && (i < FP) && (i < full_idx);
            if (exp_w) acc++;
            chk($sformatf("wr1_strobe[%0d]", i), 32'(bus.oWR1), 32'(exp_w));
            chk($sformatf("wr2_strobe[%0d]", i), 32'(bus.oWR2), 32'(exp_w));
            if (exp_w) begin
                chk($sformatf("wr1_data[%0d]", i), 32'(bus.oWR1_DATA), 32'(vecs[k].d1));
                chk($sformatf("wr2_data[%0d]", i), 32'(bus.oWR2_DATA), 32'(vecs[k].d2));
            end
        end
        chk("load_in_frame", loads_tot - load_base, 0);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iWR2_FULL = 1'b0;
        cyc();
        chk("frame_done", 32'(done), 32'(armed));
        if (armed) begin
            chk("frame_ok", 32'(ok), 32'(exp_ok));
            chk("frame_cnt", 32'(fcnt), exp_fcnt);
            chk("pix_cnt", 32'(pcnt), acc);
        end
        chk("strobe_count", strobes_tot - strobe_base, acc);
        cyc();
        chk("done_pulse_len", 32'(done), 0);
        chk("done_count", dones_tot - done_base, 32'(armed));
    endtask

    initial begin
        vecs[0] = '{10'h3FF, 10'h2A5, 10'h001, 16'h5401, 16'h17FF};
        vecs[1] = '{10'h000, 10'h000, 10'h000, 16'h0000, 16'h0000};
        vecs[2] = '{10'h3FF, 10'h3FF, 10'h3FF, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{10'h155, 10'h01F, 10'h2AA, 16'h02AA, 16'h7D55};
        vecs[4] = '{10'h001, 10'h3E0, 10'h200, 16'h7E00, 16'h0001};

        rst = 1'b1;
        en  = 1'b0;
        bus.iFVAL = 1'b0; bus.iDVAL = 1'b0;
        bus.iRED = '0; bus.iGREEN = '0; bus.iBLUE = '0;
        bus.iWR1_FULL = 1'b0; bus.iWR2_FULL = 1'b0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Enable in blanking: reload pulse, then the first full frame.
        load_base = loads_tot;
        en = 1'b1;
        blank(4);
        run_frame(16, NONE, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1, 1);
        blank(4);

        // Long frame: extra pixels are discarded, not treated as overflow.
        run_frame(20, NONE, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1);
        chk("ovf_after_long", 32'(ovf), 0);
        blank(4);

        run_frame(10, NONE, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1);
        blank(4);

        // FIFO 2 full on the 5th pixel: rest of the frame dropped.
        run_frame(16, 4, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1);
        chk("ovf_set", 32'(ovf), 1);
        blank(4);

        // Recovery frame with a pixel already present in the rise cycle.
        run_frame(16, NONE, 1'b1, 1'b1, -1, -1, 1'b1, 1'b1, 2);
        chk("ovf_sticky", 32'(ovf), 1);
        en = 1'b0;
        blank(4);

        // Enable raised mid-frame: ignored until the frame ends, then a reload.
        run_frame(8, NONE, 1'b0, 1'b1, 3, -1, 1'b0, 1'b0, 0);
        blank(4);

        // Enable dropped mid-frame: frame completes, then no reload.
        run_frame(16, NONE, 1'b0, 1'b1, -1, 8, 1'b1, 1'b1, 3);
        blank(0);

        // Reset while ACTIVE.
        en = 1'b1;
        load_base = loads_tot;
        blank(4);
        bus.iFVAL = 1'b1;
        bus.iDVAL = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive_pix(i + 2);
            cyc();
        end
        chk("pre_reset_strobe", 32'(bus.oWR1), 1);
        done_base = dones_tot;
        drive_pix(0);
        rst = 1'b1;
        cyc();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        load_base = loads_tot;
        repeat (2) cyc();
        chk("post_reset_wr", 32'(bus.oWR1), 0);
        chk("post_reset_load", loads_tot - load_base, 0);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        cyc();
        chk("load_after_fall", 32'(bus.oWR_LOAD), 1);
        cyc();
        chk("no_done_after_reset", dones_tot - done_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_frame_writer.md
Name: sdram_frame_writer

Overview:
Write-side feeder for the 4-port SDRAM controller's two write FIFOs. It takes the 30-bit RGB pixel stream from the camera colour-conversion stage and splits each pixel into two 16-bit words, one per FIFO, with matched write strobes. It issues a FIFO-clear/address-reload pulse in vertical blanking before each frame, so every captured frame starts at the base address. It detects FIFO overflow and frame-length errors and reports per-frame status.

Parameters:
FRAME_PIXELS, 307200, expected pixels per frame (640*480)
LOAD_CYCLES, 4, length of the oWR_LOAD pulse in CLK cycles (1..15)
PCNT_W, 19, pixel counter width; must satisfy 2^PCNT_W > FRAME_PIXELS

Ports:
CLK  in  1  single clock; the camera pixel clock, also the write-FIFO write clock
RESET  in  1  synchronous, active-high reset
iENABLE  in  1  capture enable
iFVAL  in  1  frame valid
iDVAL  in  1  pixel valid (qualified by iFVAL)
iRED  in  10  red component
iGREEN  in  10  green component
iBLUE  in  10  blue component
iWR1_FULL  in  1  write FIFO 1 full
iWR2_FULL  in  1  write FIFO 2 full
oWR1_DATA  out  16  {1'b0, G[9:5], B[9:0]}
oWR1  out  1  FIFO 1 write strobe
oWR2_DATA  out  16  {1'b0, G[4:0], R[9:0]}
oWR2  out  1  FIFO 2 write strobe, always equal to oWR1
oWR_LOAD  out  1  FIFO clear / address reload, drives both WR1_LOAD and WR2_LOAD
oFRAME_DONE  out  1  one-cycle pulse at the end of each captured frame
oFRAME_OK  out  1  status of the last frame, valid from oFRAME_DONE onward
oOVERFLOW  out  1  sticky: a pixel was dropped because a FIFO was full
oFRAME_CNT  out  16  count of good frames, wraps
oPIX_CNT  out  PCNT_W  pixels accepted in the current or last frame

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Every output is 0: oWR1, oWR2, both data buses, oWR_LOAD, oFRAME_DONE, oFRAME_OK, oOVERFLOW, oFRAME_CNT, oPIX_CNT.
  - Reset mid-frame abandons the frame; no oFRAME_DONE is issued.
- Edge detection: fval_d is iFVAL registered. Rise = iFVAL & ~fval_d; fall = ~iFVAL & fval_d.
- Accept condition: accept = state==ACTIVE & iFVAL & iDVAL & oPIX_CNT<FRAME_PIXELS & ~iWR1_FULL & ~iWR2_FULL.
- Accept timing: an accepted pixel at edge k gives oWR1=oWR2=1 with registered data in cycle k+1. Latency is 1 cycle. The strobe is never asserted without a matching accept.
- oPIX_CNT increments by 1 per accept. It is cleared on entry to ACTIVE.
- States:
  - IDLE: if iENABLE & ~iFVAL, go to LOAD. If iFVAL is high, wait; a frame is never entered mid-way.
  - LOAD: oWR_LOAD=1 for exactly LOAD_CYCLES cycles, then go to ARMED. iFVAL rising during LOAD is a protocol violation. The block goes to DROP for that frame and does not write.
  - ARMED: on rise, go to ACTIVE. A pixel present in the rise cycle is accepted. If iENABLE drops while ARMED, go to IDLE.
  - ACTIVE:
    - If a pixel is qualified (iFVAL & iDVAL) while either FULL is high, the pixel is dropped, oOVERFLOW is set, frame_err is set, and the state goes to DROP.
    - Pixels beyond FRAME_PIXELS are discarded and set frame_err. This is not an overflow.
    - On fall: oFRAME_DONE=1 for one cycle.
      - oFRAME_OK = ~frame_err & (oPIX_CNT==FRAME_PIXELS).
      - oFRAME_CNT increments if OK.
      - Next state is LOAD if iENABLE, else IDLE.
  - DROP: no writes. On fall: oFRAME_DONE pulse with oFRAME_OK=0, then LOAD/IDLE as in ACTIVE.
- iENABLE deasserted mid-frame: the current frame completes normally; exit to IDLE at fall.
- frame_err is cleared on entry to ACTIVE.
- oOVERFLOW clears only on RESET.
- oFRAME_CNT wraps 0xFFFF to 0.

Test Plan:
- FRAME_PIXELS=16, LOAD_CYCLES=4, enable with iFVAL low -> oWR_LOAD high exactly 4 cycles. Then a frame of 16 pixels with R=0x3FF, G=0x2A5, B=0x001 -> 16 strobes, each 1 cycle after its accept, oWR1_DATA=0x5401, oWR2_DATA=0x17FF. At fall: oFRAME_DONE pulse, oFRAME_OK=1, oFRAME_CNT=1.
- iWR2_FULL asserted on the 5th pixel -> exactly 4 strobes, oOVERFLOW=1, no further writes that frame, oFRAME_OK=0, oFRAME_CNT unchanged. The next frame is preceded by oWR_LOAD and captures 16 pixels OK.
- Frame of 20 pixels -> 16 strobes, oPIX_CNT=16, oFRAME_OK=0, oOVERFLOW stays 0.
- Frame of 10 pixels -> 10 strobes, oFRAME_OK=0.
- Enable raised while iFVAL high mid-frame -> no LOAD and no writes until iFVAL falls. LOAD then precedes the next frame. Enable dropped mid-frame -> the frame completes, then IDLE with no LOAD.
- RESET asserted during ACTIVE -> next cycle all outputs 0, state IDLE, no oFRAME_DONE pulse.
